// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU byte-stream sequencer.
package alu_seq_pkg;

  localparam int unsigned NB_DATA_DEF   = 8;
  localparam int unsigned NB_OP_DEF     = 6;
  localparam int unsigned FLAG_ZERO_BIT = 0;
  localparam int unsigned FLAG_OVF_BIT  = 1;

  typedef enum logic [2:0] {
    ST_GET_A,
    ST_GET_B,
    ST_GET_OP,
    ST_SETTLE,
    ST_CAPTURE,
    ST_TX_RES,
    ST_TX_FLAGS
  } state_t;

endpackage

// File: rtl/alu_seq_timer.sv
// Clearable saturating idle counter; o_tc_c flags the cycle the count reaches TIMEOUT_CYC.
module alu_seq_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en && (cnt_q != CW'(TIMEOUT_CYC))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle.
  assign o_tc_c = i_en && !i_clr && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Byte-stream sequencer loading A/B/OP into the ALU and returning result and flags.
// Optional inter-byte timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned NB_DATA     = NB_DATA_DEF,
  parameter int unsigned NB_OP       = NB_OP_DEF,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  output logic [NB_DATA-1:0] o_alu_data,
  output logic               o_en_a,
  output logic               o_en_b,
  output logic               o_en_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_zero,
  input  logic               i_alu_overflow,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_err
);

  state_t             state_q;
  state_t             state_d;
  logic               rx_accept_c;
  logic               timeout_c;
  logic               zero_q;
  logic               ovf_q;
  logic [NB_DATA-1:0] flags_byte_c;
  logic               unused_cfg;

  // Ready and busy are plain decodes of the state register.
  assign o_rx_ready  = (state_q == ST_GET_A) || (state_q == ST_GET_B) || (state_q == ST_GET_OP);
  assign o_busy      = (state_q != ST_GET_A);
  assign rx_accept_c = i_rx_valid && o_rx_ready;

`ifdef ALU_SEQ_TIMEOUT_EN
  alu_seq_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (rx_accept_c || (state_q == ST_GET_A)),
    .i_en   ((state_q == ST_GET_B) || (state_q == ST_GET_OP)),
    .o_tc_c (timeout_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else begin
      o_err <= timeout_c;
    end
  end

  assign unused_cfg = ^{32'(NB_OP)};
`else
  assign timeout_c  = 1'b0;
  assign o_err      = 1'b0;
  assign unused_cfg = ^{32'(NB_OP), 32'(TIMEOUT_CYC)};
`endif

  always_comb begin
    flags_byte_c                = '0;
    flags_byte_c[FLAG_ZERO_BIT] = zero_q;
    flags_byte_c[FLAG_OVF_BIT]  = ovf_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_GET_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accepts advance the GET states, the TX states wait on downstream ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GET_A:    if (rx_accept_c) state_d = ST_GET_B;
      ST_GET_B:    if (rx_accept_c) state_d = ST_GET_OP;
                   else if (timeout_c) state_d = ST_GET_A;
      ST_GET_OP:   if (rx_accept_c) state_d = ST_SETTLE;
                   else if (timeout_c) state_d = ST_GET_A;
      ST_SETTLE:   state_d = ST_CAPTURE;
      ST_CAPTURE:  state_d = ST_TX_RES;
      ST_TX_RES:   if (i_tx_ready) state_d = ST_TX_FLAGS;
      ST_TX_FLAGS: if (i_tx_ready) state_d = ST_GET_A;
      default:     state_d = ST_GET_A;
    endcase
  end

  // Registered ALU load bus, enables and outgoing byte stream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu_data <= '0;
      o_en_a     <= 1'b0;
      o_en_b     <= 1'b0;
      o_en_op    <= 1'b0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      o_en_a  <= rx_accept_c && (state_q == ST_GET_A);
      o_en_b  <= rx_accept_c && (state_q == ST_GET_B);
      o_en_op <= rx_accept_c && (state_q == ST_GET_OP);
      if (rx_accept_c) begin
        o_alu_data <= i_rx_data;
      end
      case (state_q)
        ST_CAPTURE: begin
          zero_q     <= i_alu_zero;
          ovf_q      <= i_alu_overflow;
          o_tx_data  <= i_alu_result;
          o_tx_valid <= 1'b1;
        end
        ST_TX_RES: begin
          if (i_tx_ready) begin
            o_tx_data <= flags_byte_c;
          end
        end
        ST_TX_FLAGS: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl wrapped with a behavioural ALU (ADD 0x20, SUB 0x22).
module tb_alu_seq_ctrl;

  localparam int unsigned NB_DATA     = 8;
  localparam int unsigned NB_OP       = 6;
  localparam int unsigned TIMEOUT_CYC = 20;

  logic               i_clk;
  logic               i_rst_n;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               o_rx_ready;
  logic [NB_DATA-1:0] o_alu_data;
  logic               o_en_a;
  logic               o_en_b;
  logic               o_en_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_alu_zero;
  logic               i_alu_overflow;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               o_busy;
  logic               o_err;

  alu_seq_ctrl #(
    .NB_DATA    (NB_DATA),
    .NB_OP      (NB_OP),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rx_data     (i_rx_data),
    .i_rx_valid    (i_rx_valid),
    .o_rx_ready    (o_rx_ready),
    .o_alu_data    (o_alu_data),
    .o_en_a        (o_en_a),
    .o_en_b        (o_en_b),
    .o_en_op       (o_en_op),
    .i_alu_result  (i_alu_result),
    .i_alu_zero    (i_alu_zero),
    .i_alu_overflow(i_alu_overflow),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural ALU top: registers loaded by the enables, combinational result.
  logic [7:0] alu_a, alu_b, alu_op;
  always @(posedge i_clk) begin
    if (o_en_a)  alu_a  <= o_alu_data;
    if (o_en_b)  alu_b  <= o_alu_data;
    if (o_en_op) alu_op <= o_alu_data;
  end
  always_comb begin
    i_alu_result   = 8'h00;
    i_alu_overflow = 1'b0;
    case (alu_op[5:0])
      6'h20: begin
        i_alu_result   = alu_a + alu_b;
        i_alu_overflow = (alu_a[7] == alu_b[7]) && (i_alu_result[7] != alu_a[7]);
      end
      6'h22: begin
        i_alu_result   = alu_a - alu_b;
        i_alu_overflow = (alu_a[7] != alu_b[7]) && (i_alu_result[7] != alu_a[7]);
      end
      default: ;
    endcase
    i_alu_zero = (i_alu_result == 8'h00);
  end

  // Downstream ready: either held by the sequence or randomised each cycle.
  logic rdy_hold, rand_rdy, rnd_bit;
  always @(posedge i_clk) rnd_bit <= 1'($urandom);
  assign i_tx_ready = rand_rdy ? rnd_bit : rdy_hold;

  int n_checks = 0;
  int n_pass   = 0;
  int n_en_a, n_en_b, n_en_op;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Integer reference for ADD/SUB: {flags byte, result byte}.
  function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] op);
    int s;
    logic [7:0] r;
    logic ovf;
    s   = (op == 8'h20) ? (int'($signed(a)) + int'($signed(b)))
                        : (int'($signed(a)) - int'($signed(b)));
    r   = 8'(s);
    ovf = (s > 127) || (s < -128);
    return {6'b0, ovf, (r == 8'h00), r};
  endfunction

  // TX monitor pops the scoreboard on every transfer; also counts enable pulses.
  always @(negedge i_clk) begin
    if (i_rst_n && o_tx_valid && i_tx_ready) begin
      if (exp_q.size() == 0) check_eq("tx_unexpected", 32'(exp_q.size()), 32'd1);
      else check_eq("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
    end
    if (o_en_a)  n_en_a++;
    if (o_en_b)  n_en_b++;
    if (o_en_op) n_en_op++;
  end

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      if (o_rx_ready) break;
      if (c == 199) check_eq("rx_accept_timeout", 32'(o_rx_ready), 32'd1);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 300; c++) begin
      @(negedge i_clk);
      if (!o_busy && exp_q.size() == 0) break;
      if (c == 299) check_eq(tag, 32'(exp_q.size()), 32'd0);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                     input logic [7:0] er, input logic [7:0] ef, input bit chk_lat);
    int lat;
    exp_q.push_back(er);
    exp_q.push_back(ef);
    n_en_a = 0; n_en_b = 0; n_en_op = 0;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    i_rx_valid = 1'b0;
    if (chk_lat) begin
      lat = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge i_clk);
        lat++;
        if (c == 0) check_eq("settle_en_op", 32'(o_en_op), 32'd1);
        if (o_tx_valid) break;
      end
      check_eq("op_to_tx_latency", 32'(lat), 32'd3);
    end
    wait_idle("txn_done_timeout");
    check_eq("en_a_count", 32'(n_en_a), 32'd1);
    check_eq("en_b_count", 32'(n_en_b), 32'd1);
    check_eq("en_op_count", 32'(n_en_op), 32'd1);
  endtask

  task automatic wait_tx_valid(input string tag);
    for (int c = 0; c < 50; c++) begin
      @(negedge i_clk);
      if (o_tx_valid) break;
      if (c == 49) check_eq(tag, 32'(o_tx_valid), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] a, b, op;
    logic [15:0] r;
    i_rst_n    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    rdy_hold   = 1'b1;
    rand_rdy   = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_rx_ready", 32'(o_rx_ready), 32'd1);
    check_eq("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(o_tx_data), 32'd0);
    check_eq("rst_alu_data", 32'(o_alu_data), 32'd0);
    check_eq("rst_enables", 32'({o_en_a, o_en_b, o_en_op}), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_err", 32'(o_err), 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    txn(8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 1'b1);
    txn(8'h03, 8'h03, 8'h22, 8'h00, 8'h01, 1'b1);
    txn(8'h7F, 8'h01, 8'h20, 8'h80, 8'h02, 1'b1);

    // Downstream stall: output must hold and no new bytes accepted.
    rdy_hold = 1'b0;
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h00);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h22);
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h55;
    wait_tx_valid("stall_tx_valid_timeout");
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge i_clk);
      check_eq("stall_tx_valid", 32'(o_tx_valid), 32'd1);
      check_eq("stall_tx_data", 32'(o_tx_data), 32'hF0);
      check_eq("stall_rx_ready", 32'(o_rx_ready), 32'd0);
    end
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
    rdy_hold   = 1'b1;
    wait_idle("stall_done_timeout");

    // Reset while the result byte is being offered.
    rdy_hold = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h20);
    i_rx_valid = 1'b0;
    wait_tx_valid("rst_mid_tx_valid_timeout");
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tx_valid", 32'(o_tx_valid), 32'd0);
    check_eq("rst_mid_busy", 32'(o_busy), 32'd0);
    check_eq("rst_mid_rx_ready", 32'(o_rx_ready), 32'd1);
    exp_q.delete();
    @(posedge i_clk);
    #1;
    i_rst_n  = 1'b1;
    rdy_hold = 1'b1;
    txn(8'h02, 8'h02, 8'h20, 8'h04, 8'h00, 1'b0);

`ifdef ALU_SEQ_TIMEOUT_EN
    begin
      int idle;
      send_byte(8'h05);
      i_rx_valid = 1'b0;
      idle = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge i_clk);
        idle++;
        if (o_err) break;
      end
      check_eq("timeout_cycles", 32'(idle), 32'(TIMEOUT_CYC + 1));
      check_eq("timeout_err", 32'(o_err), 32'd1);
      check_eq("timeout_busy", 32'(o_busy), 32'd0);
      @(negedge i_clk);
      check_eq("timeout_err_pulse", 32'(o_err), 32'd0);
      @(posedge i_clk);
      #1;
      txn(8'h01, 8'h02, 8'h20, 8'h03, 8'h00, 1'b0);
    end
`endif

    // Random ADD/SUB transactions with randomised downstream ready.
    rand_rdy = 1'b1;
    for (int t = 0; t < 8; t++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h22;
      r  = ref_alu(a, b, op);
      txn(a, b, op, r[7:0], r[15:8], 1'b0);
    end
    rand_rdy = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
